satalnk_txalign: RTL

SATALNK_TXALIGN -- requirements
Module: satalnk_txalign

---
 rtl/satalnk_pkg.sv | 34 +++
 rtl/satalnk_txalign.sv | 121 ++++++++++++
 2 files changed

// File: rtl/satalnk_pkg.sv
// Shared SATA link-layer definitions.
//   - Primitive dwords as transmitted (K28.5-led control words).
//   - 33-bit primitive words {primitive flag, dword} for the TX path.
//   - State encoding for the TX ALIGN inserter (satalnk_txalign).
package satalnk_pkg;

    // Primitive dwords
    localparam logic [31:0] DW_ALIGN = 32'h7b4a_4abc;
    localparam logic [31:0] DW_SYNC  = 32'hb5b5_957c;
    localparam logic [31:0] DW_CONT  = 32'h9999_aa7c;
    localparam logic [31:0] DW_DMAT  = 32'h3636_b57c;
    localparam logic [31:0] DW_EOF   = 32'hd5d5_b57c;
    localparam logic [31:0] DW_HOLD  = 32'hd5d5_aa7c;
    localparam logic [31:0] DW_HOLDA = 32'h9595_aa7c;
    localparam logic [31:0] DW_R_ERR = 32'h5656_b57c;
    localparam logic [31:0] DW_R_IP  = 32'h5555_b57c;
    localparam logic [31:0] DW_R_OK  = 32'h3535_b57c;
    localparam logic [31:0] DW_R_RDY = 32'h4a4a_957c;
    localparam logic [31:0] DW_SOF   = 32'h3737_b57c;
    localparam logic [31:0] DW_WTRM  = 32'h5858_b57c;
    localparam logic [31:0] DW_X_RDY = 32'h5757_b57c;

    // {primitive flag, dword} forms used by the TX path
    localparam logic [32:0] PRIM_ALIGN = {1'b1, DW_ALIGN};
    localparam logic [32:0] PRIM_SYNC  = {1'b1, DW_SYNC};

    // TX ALIGN inserter states
    typedef logic [1:0] txalign_state_t;

    localparam txalign_state_t ST_NORMAL = 2'd0;
    localparam txalign_state_t ST_ALIGN1 = 2'd1;
    localparam txalign_state_t ST_ALIGN2 = 2'd2;

endpackage

// File: rtl/satalnk_txalign.sv
// SATA link TX dword mux with periodic ALIGN-pair insertion.
// Selects, per PHY dword slot, between an ALIGN pair, the framed packet
// stream, a link-FSM primitive request and SYNC, and registers the result.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   s_valid/s_ready         packet stream handshake
//   s_primitive, s_data     packet dword and its primitive flag
//   s_last                  last beat of the packet (EOF)
//   i_prim_valid, i_prim    link-FSM primitive request
//   o_prim_ready            primitive request accepted this cycle
//   i_phy_ready             PHY consumes one dword this cycle
//   o_phy_primitive/_data   registered dword to the PHY
module satalnk_txalign
    import satalnk_pkg::*;
#(
    parameter logic [32:0] P_ALIGN          = PRIM_ALIGN,
    parameter logic [32:0] P_SYNC           = PRIM_SYNC,
    parameter int unsigned P_ALIGN_INTERVAL = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_primitive,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic        i_prim_valid,
    input  logic [31:0] i_prim,
    output logic        o_prim_ready,
    input  logic        i_phy_ready,
    output logic        o_phy_primitive,
    output logic [31:0] o_phy_data
);

    localparam int unsigned     CntW    = $clog2(P_ALIGN_INTERVAL);
    localparam logic [CntW-1:0] CntLast = CntW'(P_ALIGN_INTERVAL - 1);

    txalign_state_t  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            in_packet_q, in_packet_d;
    logic [32:0]     out_q, out_d;

    logic normal;
    logic last_slot;
    logic s_fire;
    logic p_fire;

    assign normal    = (state_q == ST_NORMAL);
    assign last_slot = (cnt_q == CntLast);

    // The last NORMAL slot of an interval still carries a source dword; the
    // sources stall only during the two ALIGN slots that follow it. Once a
    // packet has started, the primitive path is locked out until EOF.
    assign s_ready      = i_phy_ready && normal && (in_packet_q || !i_prim_valid);
    assign o_prim_ready = i_phy_ready && normal && !in_packet_q;

    // Mutually exclusive by construction of the two readies.
    assign s_fire = s_valid && s_ready;
    assign p_fire = i_prim_valid && o_prim_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_packet_d = in_packet_q;
        out_d       = out_q;

        if (i_phy_ready) begin
            case (state_q)
                ST_NORMAL: begin
                    if (last_slot) begin
                        cnt_d   = '0;
                        state_d = ST_ALIGN1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end

                    if (s_fire) begin
                        out_d       = {s_primitive, s_data};
                        in_packet_d = !s_last;
                    end else if (p_fire) begin
                        out_d = {1'b1, i_prim};
                    end else begin
                        out_d = P_SYNC;
                    end
                end
                ST_ALIGN1: begin
                    out_d   = P_ALIGN;
                    state_d = ST_ALIGN2;
                end
                ST_ALIGN2: begin
                    out_d   = P_ALIGN;
                    state_d = ST_NORMAL;
                end
                default: begin
                    // Unreachable encoding: recover to NORMAL with an idle dword.
                    out_d   = P_SYNC;
                    state_d = ST_NORMAL;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_NORMAL;
            cnt_q       <= '0;
            in_packet_q <= 1'b0;
            out_q       <= P_SYNC;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_packet_q <= in_packet_d;
            out_q       <= out_d;
        end
    end

    assign o_phy_primitive = out_q[32];
    assign o_phy_data      = out_q[31:0];

endmodule
